// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_decoder
// Description : Parses framed WRITE/FILL commands from the UART receive byte
//               stream, issues framebuffer write strobes, reports checksum
//               status and resynchronises on inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ADDR_WIDTH     = 10,
    parameter int         TIMEOUT_CYCLES = 120000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_uart_received,
    input  logic [7:0]            i_uart_rx_byte,
    output logic                  o_fb_we,
    output logic [ADDR_WIDTH-1:0] o_fb_addr,
    output logic [7:0]            o_fb_data,
    output logic                  o_frame_ok,
    output logic                  o_frame_err,
    output logic                  o_rx_dropped,
    output logic                  o_busy
);

    localparam logic [7:0] c_CMD_WRITE = 8'h01;
    localparam logic [7:0] c_CMD_FILL  = 8'h02;

    // AHI bits that would address beyond the framebuffer
    localparam logic [7:0] c_AHI_ILLEGAL = 8'(8'hFF << (ADDR_WIDTH - 8));

    localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CMD  = 4'd1,
        S_AHI  = 4'd2,
        S_ALO  = 4'd3,
        S_LEN  = 4'd4,
        S_DATA = 4'd5,
        S_FVAL = 4'd6,
        S_CHK  = 4'd7,
        S_FILL = 4'd8
    } state_t;

    state_t                  r_state,      w_state_next;
    logic                    r_is_fill,    w_is_fill_next;
    logic [7:0]              r_ahi,        w_ahi_next;
    logic [ADDR_WIDTH-1:0]   r_addr,       w_addr_next;     // next write address
    logic [8:0]              r_len,        w_len_next;      // bytes/writes remaining
    logic [7:0]              r_chk,        w_chk_next;      // running XOR
    logic [7:0]              r_val,        w_val_next;      // FILL value
    logic [c_TMO_W-1:0]      r_tmo,        w_tmo_next;
    logic                    r_fb_we,      w_fb_we_next;
    logic [ADDR_WIDTH-1:0]   r_fb_addr,    w_fb_addr_next;
    logic [7:0]              r_fb_data,    w_fb_data_next;
    logic                    r_frame_ok,   w_frame_ok_next;
    logic                    r_frame_err,  w_frame_err_next;
    logic                    r_rx_dropped, w_rx_dropped_next;
    logic                    r_busy;

    logic                    w_in_frame;
    logic                    w_tmo_hit;
    logic                    w_ahi_bad;

    assign w_in_frame = (r_state != S_IDLE) && (r_state != S_FILL);
    assign w_tmo_hit  = w_in_frame && !i_uart_received && (r_tmo == c_TMO_LAST);
    assign w_ahi_bad  = |(i_uart_rx_byte & c_AHI_ILLEGAL);

    // State and datapath registers; everything returns to zero/IDLE on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_fill    <= 1'b0;
            r_ahi        <= 8'h00;
            r_addr       <= '0;
            r_len        <= 9'd0;
            r_chk        <= 8'h00;
            r_val        <= 8'h00;
            r_tmo        <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= 8'h00;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_dropped <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_is_fill    <= w_is_fill_next;
            r_ahi        <= w_ahi_next;
            r_addr       <= w_addr_next;
            r_len        <= w_len_next;
            r_chk        <= w_chk_next;
            r_val        <= w_val_next;
            r_tmo        <= w_tmo_next;
            r_fb_we      <= w_fb_we_next;
            r_fb_addr    <= w_fb_addr_next;
            r_fb_data    <= w_fb_data_next;
            r_frame_ok   <= w_frame_ok_next;
            r_frame_err  <= w_frame_err_next;
            r_rx_dropped <= w_rx_dropped_next;
            r_busy       <= (w_state_next == S_FILL);
        end
    end

    // Frame parser: next state, datapath updates and output pulses
    always_comb begin
        w_state_next      = r_state;
        w_is_fill_next    = r_is_fill;
        w_ahi_next        = r_ahi;
        w_addr_next       = r_addr;
        w_len_next        = r_len;
        w_chk_next        = r_chk;
        w_val_next        = r_val;
        w_fb_we_next      = 1'b0;
        w_fb_addr_next    = r_fb_addr;
        w_fb_data_next    = r_fb_data;
        w_frame_ok_next   = 1'b0;
        w_frame_err_next  = 1'b0;
        w_rx_dropped_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_uart_received && (i_uart_rx_byte == SYNC_BYTE)) begin
                    w_chk_next   = 8'h00;
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (i_uart_received) begin
                    if ((i_uart_rx_byte == c_CMD_WRITE) || (i_uart_rx_byte == c_CMD_FILL)) begin
                        w_is_fill_next = (i_uart_rx_byte == c_CMD_FILL);
                        w_chk_next     = i_uart_rx_byte;
                        w_state_next   = S_AHI;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = S_IDLE;
                    end
                end
            end
            S_AHI: begin
                if (i_uart_received) begin
                    if (w_ahi_bad) begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = S_IDLE;
                    end else begin
                        w_ahi_next   = i_uart_rx_byte;
                        w_chk_next   = r_chk ^ i_uart_rx_byte;
                        w_state_next = S_ALO;
                    end
                end
            end
            S_ALO: begin
                if (i_uart_received) begin
                    w_addr_next  = ADDR_WIDTH'({r_ahi, i_uart_rx_byte});
                    w_chk_next   = r_chk ^ i_uart_rx_byte;
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (i_uart_received) begin
                    // LEN of zero encodes 256
                    w_len_next   = (i_uart_rx_byte == 8'h00) ? 9'd256 : {1'b0, i_uart_rx_byte};
                    w_chk_next   = r_chk ^ i_uart_rx_byte;
                    w_state_next = r_is_fill ? S_FVAL : S_DATA;
                end
            end
            S_DATA: begin
                if (i_uart_received) begin
                    w_fb_we_next   = 1'b1;
                    w_fb_addr_next = r_addr;
                    w_fb_data_next = i_uart_rx_byte;
                    w_addr_next    = r_addr + c_ADDR_ONE;
                    w_len_next     = r_len - 9'd1;
                    w_chk_next     = r_chk ^ i_uart_rx_byte;
                    if (r_len == 9'd1) begin
                        w_state_next = S_CHK;
                    end
                end
            end
            S_FVAL: begin
                if (i_uart_received) begin
                    w_val_next   = i_uart_rx_byte;
                    w_chk_next   = r_chk ^ i_uart_rx_byte;
                    w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (i_uart_received) begin
                    if (i_uart_rx_byte == r_chk) begin
                        w_frame_ok_next = 1'b1;
                        w_state_next    = r_is_fill ? S_FILL : S_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = S_IDLE;
                    end
                end
            end
            S_FILL: begin
                // One write per cycle; incoming bytes are discarded and flagged
                w_fb_we_next   = 1'b1;
                w_fb_addr_next = r_addr;
                w_fb_data_next = r_val;
                w_addr_next    = r_addr + c_ADDR_ONE;
                w_len_next     = r_len - 9'd1;
                if (r_len == 9'd1) begin
                    w_state_next = S_IDLE;
                end
                if (i_uart_received) begin
                    w_rx_dropped_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Inter-byte timeout aborts a partial frame; a byte on the expiry cycle wins
        if (w_tmo_hit) begin
            w_frame_err_next = 1'b1;
            w_state_next     = S_IDLE;
        end
    end

    // Inter-byte timeout counter, only runs while a frame is in progress
    always_comb begin
        w_tmo_next = r_tmo + c_TMO_ONE;
        if (i_uart_received || !w_in_frame || w_tmo_hit) begin
            w_tmo_next = '0;
        end
    end

    assign o_fb_we      = r_fb_we;
    assign o_fb_addr    = r_fb_addr;
    assign o_fb_data    = r_fb_data;
    assign o_frame_ok   = r_frame_ok;
    assign o_frame_err  = r_frame_err;
    assign o_rx_dropped = r_rx_dropped;
    assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_decoder
// Description : Self-checking bench for uart_frame_decoder: table of framed
//               commands plus hand-written latency, timeout, FILL and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_decoder;

    localparam int c_AW = 10;
    localparam int c_TC = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_uart_received = 1'b0;
    logic [7:0]      i_uart_rx_byte  = 8'h00;
    logic            o_fb_we;
    logic [c_AW-1:0] o_fb_addr;
    logic [7:0]      o_fb_data;
    logic            o_frame_ok;
    logic            o_frame_err;
    logic            o_rx_dropped;
    logic            o_busy;

    uart_frame_decoder #(
        .SYNC_BYTE      (8'hA5),
        .ADDR_WIDTH     (c_AW),
        .TIMEOUT_CYCLES (c_TC)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .i_uart_received (i_uart_received),
        .i_uart_rx_byte  (i_uart_rx_byte),
        .o_fb_we         (o_fb_we),
        .o_fb_addr       (o_fb_addr),
        .o_fb_data       (o_fb_data),
        .o_frame_ok      (o_frame_ok),
        .o_frame_err     (o_frame_err),
        .o_rx_dropped    (o_rx_dropped),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    // Event monitor: records every write and counts pulses
    int        cyc = 0;
    int        wr_n = 0;
    logic [c_AW-1:0] wr_a [0:2047];
    logic [7:0]      wr_d [0:2047];
    int        wr_cyc [0:2047];
    int        ok_n = 0, err_n = 0, drop_n = 0, ok_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_fb_we && wr_n < 2048) begin
                wr_a[wr_n]   = o_fb_addr;
                wr_d[wr_n]   = o_fb_data;
                wr_cyc[wr_n] = cyc;
                wr_n++;
            end
            if (o_frame_ok) begin
                ok_n++;
                ok_cyc = cyc;
            end
            if (o_frame_err)  err_n++;
            if (o_rx_dropped) drop_n++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check(nm, 32'({o_fb_we, o_frame_ok, o_frame_err, o_rx_dropped, o_busy, o_fb_addr, o_fb_data}), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_uart_received = 1'b1;
        i_uart_rx_byte  = b;
        @(posedge clk);
        #1;
        i_uart_received = 1'b0;
    endtask

    // Frame table: bytes before CHK, checksum start index, CHK mode
    // (0 none, 1 correct, 2 correct+1), expected writes and pulses
    typedef struct {
        logic [0:11][7:0] b;
        int               n;
        int               c0;
        int               mode;
        int               nw;
        logic [0:3][9:0]  wa;
        logic [0:3][7:0]  wd;
        int               ok;
        int               err;
    } vec_t;

    vec_t vt [9];

    task automatic apply_vec(input int k);
        int         wb, ob, eb, db;
        logic [7:0] x;
        wb = wr_n; ob = ok_n; eb = err_n; db = drop_n;
        x = 8'h00;
        for (int i = 0; i < vt[k].n; i++) begin
            send_byte(vt[k].b[i]);
            if (i >= vt[k].c0) x = x ^ vt[k].b[i];
        end
        if (vt[k].mode == 2) x = x + 8'h01;
        if (vt[k].mode != 0) send_byte(x);
        repeat (30) @(posedge clk);
        #1;
        check($sformatf("v%0d_nwr", k), 32'(wr_n - wb), 32'(vt[k].nw));
        for (int i = 0; i < vt[k].nw && i < 4; i++) begin
            check($sformatf("v%0d_addr%0d", k, i), 32'(wr_a[wb+i]), 32'(vt[k].wa[i]));
            check($sformatf("v%0d_data%0d", k, i), 32'(wr_d[wb+i]), 32'(vt[k].wd[i]));
        end
        check($sformatf("v%0d_ok", k),   32'(ok_n - ob),   32'(vt[k].ok));
        check($sformatf("v%0d_err", k),  32'(err_n - eb),  32'(vt[k].err));
        check($sformatf("v%0d_drop", k), 32'(drop_n - db), 32'h0);
    endtask

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         wb, ob, eb, db, bad, early;

        vt[0] = '{b: {8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 32'h0}, n: 8, c0: 1, mode: 1,
                  nw: 3, wa: {10'h010, 10'h011, 10'h012, 10'h000}, wd: {8'hAA, 8'hBB, 8'hCC, 8'h00}, ok: 1, err: 0};
        vt[1] = '{b: {8'hA5, 8'h01, 8'h03, 8'hFF, 8'h02, 8'h11, 8'h22, 40'h0}, n: 7, c0: 1, mode: 1,
                  nw: 2, wa: {10'h3FF, 10'h000, 10'h000, 10'h000}, wd: {8'h11, 8'h22, 8'h00, 8'h00}, ok: 1, err: 0};
        vt[2] = '{b: {8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 32'h0}, n: 8, c0: 1, mode: 2,
                  nw: 3, wa: {10'h010, 10'h011, 10'h012, 10'h000}, wd: {8'hAA, 8'hBB, 8'hCC, 8'h00}, ok: 0, err: 1};
        vt[3] = '{b: {8'hA5, 8'h07, 80'h0}, n: 2, c0: 1, mode: 0,
                  nw: 0, wa: '0, wd: '0, ok: 0, err: 1};
        vt[4] = '{b: {8'hA5, 8'h01, 8'h04, 72'h0}, n: 3, c0: 1, mode: 0,
                  nw: 0, wa: '0, wd: '0, ok: 0, err: 1};
        vt[5] = '{b: {8'h55, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 16'h0}, n: 10, c0: 3, mode: 1,
                  nw: 3, wa: {10'h010, 10'h011, 10'h012, 10'h000}, wd: {8'hAA, 8'hBB, 8'hCC, 8'h00}, ok: 1, err: 0};
        vt[6] = '{b: {8'hA5, 8'h02, 8'h03, 8'hFE, 8'h03, 8'h5A, 48'h0}, n: 6, c0: 1, mode: 1,
                  nw: 3, wa: {10'h3FE, 10'h3FF, 10'h000, 10'h000}, wd: {8'h5A, 8'h5A, 8'h5A, 8'h00}, ok: 1, err: 0};
        vt[7] = '{b: {8'hA5, 8'h02, 8'h00, 8'h20, 8'h02, 8'h77, 48'h0}, n: 6, c0: 1, mode: 2,
                  nw: 0, wa: '0, wd: '0, ok: 0, err: 1};
        vt[8] = '{b: {8'hA5, 8'h01, 8'h02, 8'h34, 8'h01, 8'hA5, 48'h0}, n: 6, c0: 1, mode: 1,
                  nw: 1, wa: {10'h234, 10'h000, 10'h000, 10'h000}, wd: {8'hA5, 8'h00, 8'h00, 8'h00}, ok: 1, err: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_idle");

        // Table-driven frames
        for (int k = 0; k < 9; k++) apply_vec(k);

        // Write latency and fb_data hold
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h40); send_byte(8'h01);
        send_byte(8'h9C);
        @(negedge clk);
        check("lat_we",   32'(o_fb_we),   32'h1);
        check("lat_addr", 32'(o_fb_addr), 32'h040);
        check("lat_data", 32'(o_fb_data), 32'h9C);
        @(negedge clk);
        check("hold_we",   32'(o_fb_we),   32'h0);
        check("hold_data", 32'(o_fb_data), 32'h9C);
        send_byte(8'h01 ^ 8'h00 ^ 8'h40 ^ 8'h01 ^ 8'h9C);
        @(negedge clk);
        check("lat_ok", 32'(o_frame_ok), 32'h1);
        repeat (5) @(posedge clk);

        // Timeout after a stalled frame
        eb = err_n;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        early = 0;
        for (int j = 1; j <= c_TC; j++) begin
            @(negedge clk);
            if (o_frame_err) early = 1;
        end
        check("tmo_early", 32'(early), 32'h0);
        @(negedge clk);
        check("tmo_fire", 32'(o_frame_err), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_err_cnt", 32'(err_n - eb), 32'h1);

        // Byte arriving on the expiry cycle is processed
        ob = ok_n; eb = err_n; wb = wr_n;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        repeat (c_TC - 2) @(posedge clk);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h5E);
        send_byte(8'h01 ^ 8'h00 ^ 8'h20 ^ 8'h01 ^ 8'h5E);
        repeat (10) @(posedge clk);
        #1;
        check("exp_ok",   32'(ok_n - ob),  32'h1);
        check("exp_err",  32'(err_n - eb), 32'h0);
        check("exp_addr", 32'(wr_a[wb]),   32'h020);

        // 256-entry FILL with a byte injected mid-FILL
        wb = wr_n; ob = ok_n; eb = err_n; db = drop_n;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h02 ^ 8'h00 ^ 8'h00 ^ 8'h00 ^ 8'hFF);
        @(negedge clk);
        check("fill_ok",   32'(o_frame_ok), 32'h1);
        check("fill_busy", 32'(o_busy),     32'h1);
        check("fill_we0",  32'(o_fb_we),    32'h0);
        repeat (100) @(posedge clk);
        send_byte(8'h33);
        @(negedge clk);
        check("fill_drop", 32'(o_rx_dropped), 32'h1);
        for (int k = 0; k < 400 && o_busy; k++) @(negedge clk);
        check("fill_done", 32'(o_busy), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("fill_nwr", 32'(wr_n - wb), 32'd256);
        bad = 0;
        for (int i = 0; i < 256 && (wb + i) < 2048; i++) begin
            if (wr_a[wb+i] !== 10'(i) || wr_d[wb+i] !== 8'hFF) bad++;
            if (i > 0 && wr_cyc[wb+i] != wr_cyc[wb+i-1] + 1) bad++;
        end
        check("fill_seq",   32'(bad), 32'h0);
        check("fill_start", 32'(wr_cyc[wb]), 32'(ok_cyc + 1));
        check("fill_okcnt", 32'(ok_n - ob),   32'h1);
        check("fill_errcnt",32'(err_n - eb),  32'h0);
        check("fill_dropcnt", 32'(drop_n - db), 32'h1);

        // Reset mid-DATA
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'hAA);
        #1 rst = 1'b1;
        #1 check_zero("rst_data");
        @(posedge clk);
        #1 rst = 1'b0;
        wb = wr_n; ob = ok_n; eb = err_n;
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h01 ^ 8'h10 ^ 8'h03 ^ 8'hAA ^ 8'hBB ^ 8'hCC);
        repeat (10) @(posedge clk);
        #1;
        check("rst_data_nwr", 32'(wr_n - wb), 32'h0);
        check("rst_data_ok",  32'(ok_n - ob), 32'h0);

        // Reset mid-FILL
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h02 ^ 8'h01 ^ 8'h00 ^ 8'h00 ^ 8'h44);
        repeat (10) @(posedge clk);
        #1;
        check("rst_fill_pre", 32'(o_busy), 32'h1);
        rst = 1'b1;
        #1 check_zero("rst_fill");
        @(posedge clk);
        #1 rst = 1'b0;
        wb = wr_n;
        repeat (30) @(posedge clk);
        #1;
        check("rst_fill_nwr",  32'(wr_n - wb), 32'h0);
        check("rst_fill_busy", 32'(o_busy),    32'h0);

        // Normal decode after reset
        apply_vec(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
